// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Holds the pipeline through stallreq_for_ex while busy. The result comes back
// as {remainder, quotient} and is flagged by a one-cycle ready_o pulse.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_for_ex
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DIV_ZERO, DIV_ON, DIV_END} state_t;

    state_t           state, next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic             neg_q, neg_r;

    logic             take;
    logic             dvs_zero;
    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH:0]   rem_sh, trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_nx, quo_nx, quo_fix, rem_fix;

    assign take     = start_i & ~annul_i;
    assign dvs_zero = (opdata2_i == '0);

    // Operand magnitudes. These are only taken for DIV. DIVU uses the raw bits.
    always_comb begin
        abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    end

    // One restoring step. The sign bit of the (WIDTH+1)-bit trial is the borrow.
    // The final step result is sign-corrected here so it can go straight into result_o.
    always_comb begin
        rem_sh  = {rem, quo[WIDTH-1]};
        trial   = rem_sh - {1'b0, dvs};
        borrow  = trial[WIDTH];
        rem_nx  = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nx  = {quo[WIDTH-2:0], ~borrow};
        quo_fix = neg_q ? -quo_nx : quo_nx;
        rem_fix = neg_r ? -rem_nx : rem_nx;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic. A flush overrides everything.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (take) next_state = dvs_zero ? DIV_ZERO : DIV_ON;
            DIV_ZERO: next_state = DIV_END;
            DIV_ON:   if (cnt == LAST) next_state = DIV_END;
            DIV_END:  next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        if (annul_i) next_state = IDLE;
    end

    // Outputs. The stall request drops in DIV_END so the pipeline moves on that edge.
    always_comb begin
        ready_o         = (state == DIV_END);
        stallreq_for_ex = take & (state != DIV_END);
    end

    // Datapath: latch operands in IDLE, then iterate, then register the result.
    // On divide-by-zero, quo holds the raw dividend so it can become the remainder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_r <= signed_div_i & opdata1_i[WIDTH-1];
                    rem   <= '0;
                    cnt   <= '0;
                    dvs   <= abs2;
                    quo   <= dvs_zero ? opdata1_i : abs1;
                end
                DIV_ON: if (!annul_i) begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) result_o <= {rem_fix, quo_fix};
                end
                DIV_ZERO: if (!annul_i) result_o <= {quo, {WIDTH{1'b1}}};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed bench for div_unit. Expected results are queued when a
// divide is launched and compared when ready_o fires.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] op1, op2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          n_done = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_res = '0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start), .signed_div_i(sgn),
        .opdata1_i(op1), .opdata2_i(op2), .annul_i(annul),
        .result_o(result), .ready_o(ready), .stallreq_for_ex(stall)
    );

    always #5 clk = ~clk;

    // Count every ready pulse that the DUT emits.
    always @(negedge clk) if (ready === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Launch a divide at posedge+1 and follow it to ready_o. Start is left high,
    // so a following call continues back-to-back from IDLE.
    task automatic run_div(input string tag, input bit s, input logic [31:0] a,
                           input logic [31:0] b, input int lat);
        int          c = 0;
        int          nstall = 0;
        bit          got = 1'b0;
        logic [63:0] e;
        exp_q.push_back(model(s, a, b));
        start = 1'b1; sgn = s; op1 = a; op2 = b;
        while (!got && c <= lat + 5) begin
            #1;
            if (stall === 1'b1) nstall++;
            if (ready === 1'b1) begin
                got = 1'b1;
                chk({tag, " latency"}, 64'(c), 64'(lat));
                chk({tag, " stall cycles"}, 64'(nstall), 64'(lat));
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
                chk({tag, " result"}, result, e);
                last_res = e;
                n_done++;
            end
            @(posedge clk); #1;
            // Operands must be ignored once the divide has been launched.
            if (c == 0) begin op1 = $urandom; op2 = $urandom; end
            c++;
        end
        if (!got) begin
            chk({tag, " timeout"}, 64'(got), 64'd1);
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b0; sgn = 1'b0; op1 = '0; op2 = '0; annul = 1'b0;
        #1;
        chk("reset result", result, 64'd0);
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset stall", 64'(stall), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Main function: unsigned, signed sign combinations, overflow, and extremes.
        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 33);
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33);
        run_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33);
        run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33);
        run_div("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33);
        run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 2);
        run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 2);
        run_div("divu 3/9", 1'b0, 32'd3, 32'd9, 33);
        start = 1'b0;
        @(posedge clk); #1;

        // A flush at cycle 10 of DIV_ON: no pulse, and the result stays unchanged.
        start = 1'b1; sgn = 1'b0; op1 = 32'd1000; op2 = 32'd7;
        repeat (10) begin @(posedge clk); #1; end
        annul = 1'b1;
        #1;
        chk("annul stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        #1;
        chk("annul idle stall", 64'(stall), 64'd0);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (ready === 1'b1) seen = 1'b1; end
        chk("annul no ready", 64'(seen), 64'd0);
        chk("annul result held", result, last_res);
        @(posedge clk); #1;
        run_div("divu 9/3", 1'b0, 32'd9, 32'd3, 33);
        start = 1'b0;
        @(posedge clk); #1;

        // Async reset between edges in the middle of DIV_ON.
        start = 1'b1; sgn = 1'b0; op1 = 32'd50; op2 = 32'd5;
        repeat (6) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1; start = 1'b0;
        #1;
        chk("rst mid result", result, 64'd0);
        chk("rst mid ready", 64'(ready), 64'd0);
        chk("rst mid stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back divides, including random operands.
        run_div("b2b a", 1'b0, 32'd1234567, 32'd89, 33);
        run_div("b2b b", 1'b1, 32'hFFF0_0000, 32'd1000, 33);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 30);
            run_div("random", i[0], a, b, (b == 0) ? 2 : 33);
        end
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("ready pulse count", 64'(pulses), 64'(n_done));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
